instr_fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit CPU. Holds the program counter (PC) and instruction register (IR), and executes the control unit's PC clear, load and increment commands. Runs a request/acknowledge read handshake to instruction memory and presents the fetched word on `IR` with a valid flag. The control unit decodes from that output. Detects a stalled memory with a timeout watchdog.

---
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction fetch stage of the 16-bit CPU. Holds the program counter and the
// instruction register, executes PC clear/load/increment commands and runs a
// request/acknowledge read handshake to instruction memory, guarded by a
// timeout watchdog.
//
// Ports:
//   Clock, Reset      - rising-edge clock, asynchronous active-low reset
//   PC_CLR/LD/IC      - PC commands, priority CLR > LD > IC (CLR also aborts fetch)
//   PC_TARGET         - load value for PC_LD
//   IR_LD             - fetch command (accepted in IDLE only)
//   IMEM_REQ/ADDR     - read request and latched address to instruction memory
//   IMEM_ACK/RDATA    - single-cycle acknowledge with instruction word
//   PC, IR, IR_VALID  - program counter, instruction register, fetch-result flag
//   FETCH_BUSY        - fetch outstanding (mirrors IMEM_REQ)
//   FETCH_ERR         - sticky timeout flag, cleared by PC_CLR or reset
module instr_fetch_unit #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PC_CLR,
    input  logic              PC_LD,
    input  logic              PC_IC,
    input  logic [ADDR_W-1:0] PC_TARGET,
    input  logic              IR_LD,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [15:0]       IMEM_RDATA,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       IR,
    output logic              IR_VALID,
    output logic              FETCH_BUSY,
    output logic              FETCH_ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        wd_cnt;
    logic [8:0]        wd_inc;
    logic              launch;
    logic              complete;
    logic              expire;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       ir_q;
    logic              ir_valid_q;

    // Watchdog counts WAIT cycles already spent; the cycle that would make the
    // count reach TIMEOUT is the one that moves to ERR.
    assign wd_inc = {1'b0, wd_cnt} + 9'd1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        if (PC_CLR) begin
            // Clear aborts everything, including an ACK arriving this cycle.
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (IR_LD) begin
                        state_next = S_WAIT;
                        launch     = 1'b1;
                    end
                end
                S_WAIT: begin
                    // ACK is checked before the watchdog so a last-cycle ACK wins.
                    if (IMEM_ACK) begin
                        state_next = S_IDLE;
                        complete   = 1'b1;
                    end else if (wd_inc == 9'(TIMEOUT)) begin
                        state_next = S_ERR;
                        expire     = 1'b1;
                    end
                end
                S_ERR: begin
                    state_next = S_ERR;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Fetch datapath: address latch, IR, valid flag and watchdog.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_q     <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            wd_cnt     <= '0;
        end else if (PC_CLR) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            if (launch) begin
                addr_q     <= pc_q;
                ir_valid_q <= 1'b0;
                wd_cnt     <= '0;
            end
            if (complete) begin
                ir_q       <= IMEM_RDATA;
                ir_valid_q <= 1'b1;
            end else if (state == S_WAIT && !expire) begin
                wd_cnt <= wd_inc[7:0];
            end
        end
    end

    // PC update runs every cycle regardless of fetch state; the fetch latch
    // above samples the pre-update value.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q <= '0;
        end else if (PC_CLR) begin
            pc_q <= '0;
        end else if (PC_LD) begin
            pc_q <= PC_TARGET;
        end else if (PC_IC) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    assign PC         = pc_q;
    assign IR         = ir_q;
    assign IR_VALID   = ir_valid_q;
    assign IMEM_ADDR  = addr_q;
    assign IMEM_REQ   = (state == S_WAIT);
    assign FETCH_BUSY = (state == S_WAIT);
    assign FETCH_ERR  = (state == S_ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 15;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              PC_CLR = 1'b0;
    logic              PC_LD = 1'b0;
    logic              PC_IC = 1'b0;
    logic [ADDR_W-1:0] PC_TARGET = '0;
    logic              IR_LD = 1'b0;
    logic              IMEM_REQ;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic              IMEM_ACK = 1'b0;
    logic [15:0]       IMEM_RDATA = '0;
    logic [ADDR_W-1:0] PC;
    logic [15:0]       IR;
    logic              IR_VALID;
    logic              FETCH_BUSY;
    logic              FETCH_ERR;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset),
        .PC_CLR(PC_CLR), .PC_LD(PC_LD), .PC_IC(PC_IC), .PC_TARGET(PC_TARGET),
        .IR_LD(IR_LD),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
        .PC(PC), .IR(IR), .IR_VALID(IR_VALID),
        .FETCH_BUSY(FETCH_BUSY), .FETCH_ERR(FETCH_ERR)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: a fetch is either outstanding, failed, or absent.
    int          m_pc, m_addr, m_ir, m_waited;
    bit          m_valid, m_busy, m_err;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_pc = 0; m_addr = 0; m_ir = 0; m_waited = 0;
            m_valid = 0; m_busy = 0; m_err = 0;
        end else begin
            int old_pc;
            old_pc = m_pc;
            if (PC_CLR) begin
                m_busy = 0; m_err = 0; m_valid = 0; m_ir = 0;
            end else if (m_busy) begin
                if (IMEM_ACK) begin
                    m_ir = IMEM_RDATA; m_valid = 1; m_busy = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin
                        m_busy = 0; m_err = 1;
                    end
                end
            end else if (!m_err && IR_LD) begin
                m_busy = 1; m_addr = old_pc; m_valid = 0; m_waited = 0;
            end
            if (PC_CLR)     m_pc = 0;
            else if (PC_LD) m_pc = PC_TARGET;
            else if (PC_IC) m_pc = (m_pc + 1) % (1 << ADDR_W);
        end
    end

    // Continuous comparison on the falling edge, away from the active edge.
    always @(negedge Clock) begin
        chk("m_pc", 32'(PC), 32'(m_pc));
        chk("m_ir", 32'(IR), 32'(m_ir));
        chk("m_ir_valid", 32'(IR_VALID), 32'(m_valid));
        chk("m_req", 32'(IMEM_REQ), 32'(m_busy));
        chk("m_busy", 32'(FETCH_BUSY), 32'(m_busy));
        chk("m_err", 32'(FETCH_ERR), 32'(m_err));
        if (m_busy) chk("m_addr", 32'(IMEM_ADDR), 32'(m_addr));
    end

    task automatic quiet();
        PC_CLR = 0; PC_LD = 0; PC_IC = 0; IR_LD = 0; IMEM_ACK = 0;
    endtask

    // Inputs are applied at a falling edge; tick advances to the next one.
    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int ack_pct;
        quiet();
        repeat (3) @(negedge Clock);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_req", 32'(IMEM_REQ), 0);
        Reset = 1'b1;

        // Basic fetch at address 0, ACK one cycle after request.
        IR_LD = 1; tick();
        quiet(); IMEM_ACK = 1; IMEM_RDATA = 16'h1234;
        chk("f1_req", 32'(IMEM_REQ), 1);
        chk("f1_addr", 32'(IMEM_ADDR), 0);
        chk("f1_valid0", 32'(IR_VALID), 0);
        tick(); quiet();
        chk("f1_ir", 32'(IR), 32'h1234);
        chk("f1_valid", 32'(IR_VALID), 1);
        chk("f1_req_drop", 32'(IMEM_REQ), 0);

        // PC load, increments with wrap, then all three commands at once.
        PC_LD = 1; PC_TARGET = 8'hFE; tick(); quiet();
        chk("pc_fe", 32'(PC), 32'hFE);
        PC_IC = 1; tick(); chk("pc_ff", 32'(PC), 32'hFF);
        tick(); chk("pc_00", 32'(PC), 32'h00);
        tick(); chk("pc_01", 32'(PC), 32'h01);
        PC_CLR = 1; PC_LD = 1; PC_IC = 1; PC_TARGET = 8'h77; tick(); quiet();
        chk("pc_clr_prio", 32'(PC), 0);

        // Fetch plus increment on the same edge; PC reloaded during WAIT.
        PC_LD = 1; PC_TARGET = 8'h05; tick(); quiet();
        IR_LD = 1; PC_IC = 1; tick(); quiet();
        chk("f3_addr", 32'(IMEM_ADDR), 5);
        chk("f3_pc6", 32'(PC), 6);
        tick();
        PC_LD = 1; PC_TARGET = 8'h40; tick(); quiet();
        chk("f3_addr_hold", 32'(IMEM_ADDR), 5);
        tick();
        chk("f3_req_wait", 32'(IMEM_REQ), 1);
        IMEM_ACK = 1; IMEM_RDATA = 16'hA505; tick(); quiet();
        chk("f3_ir", 32'(IR), 32'hA505);
        chk("f3_pc40", 32'(PC), 32'h40);

        // Timeout: FETCH_ERR rises TIMEOUT edges after the launch edge.
        IR_LD = 1; tick(); quiet();
        for (int unsigned i = 1; i < TIMEOUT; i++) tick();
        chk("to_err_pre", 32'(FETCH_ERR), 0);
        chk("to_req_pre", 32'(IMEM_REQ), 1);
        tick();
        chk("to_err", 32'(FETCH_ERR), 1);
        chk("to_req", 32'(IMEM_REQ), 0);
        IR_LD = 1; tick(); quiet();
        chk("to_ignore_ld", 32'(IMEM_REQ), 0);
        chk("to_sticky", 32'(FETCH_ERR), 1);
        PC_CLR = 1; tick(); quiet();
        chk("to_clr", 32'(FETCH_ERR), 0);
        IR_LD = 1; tick(); quiet();
        IMEM_ACK = 1; IMEM_RDATA = 16'h0F0F; tick(); quiet();
        chk("to_refetch", 32'(IR), 32'h0F0F);
        chk("to_refetch_v", 32'(IR_VALID), 1);

        // Clear wins over a simultaneous ACK; stray ACK afterwards ignored.
        IR_LD = 1; tick(); quiet();
        PC_CLR = 1; IMEM_ACK = 1; IMEM_RDATA = 16'hBEEF; tick(); quiet();
        chk("ca_ir", 32'(IR), 0);
        chk("ca_valid", 32'(IR_VALID), 0);
        chk("ca_req", 32'(IMEM_REQ), 0);
        IMEM_ACK = 1; IMEM_RDATA = 16'h1111; tick(); quiet();
        chk("stray_ir", 32'(IR), 0);
        chk("stray_req", 32'(IMEM_REQ), 0);

        // Asynchronous reset in the middle of WAIT.
        PC_LD = 1; PC_TARGET = 8'h33; tick(); quiet();
        IR_LD = 1; tick(); quiet(); tick();
        #2 Reset = 1'b0;
        #1;
        chk("ar_req", 32'(IMEM_REQ), 0);
        chk("ar_pc", 32'(PC), 0);
        chk("ar_ir", 32'(IR), 0);
        chk("ar_err", 32'(FETCH_ERR), 0);
        IMEM_ACK = 1; IMEM_RDATA = 16'hDEAD;
        @(negedge Clock); quiet(); Reset = 1'b1;
        IR_LD = 1; tick(); quiet();
        chk("ar_addr0", 32'(IMEM_ADDR), 0);
        IMEM_ACK = 1; IMEM_RDATA = 16'h5678; tick(); quiet();
        chk("ar_ir2", 32'(IR), 32'h5678);

        // Randomized traffic against the model.
        ack_pct = 30;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(2))
                    0: ack_pct = 4;
                    1: ack_pct = 30;
                    default: ack_pct = 75;
                endcase
            end
            PC_CLR     = ($urandom_range(39) == 0);
            PC_LD      = ($urandom_range(9) == 0);
            PC_IC      = ($urandom_range(3) == 0);
            PC_TARGET  = ADDR_W'($urandom);
            IR_LD      = ($urandom_range(2) == 0);
            IMEM_RDATA = 16'($urandom);
            if (IMEM_REQ) IMEM_ACK = ($urandom_range(99) < ack_pct);
            else          IMEM_ACK = ($urandom_range(29) == 0);
            tick();
        end
        quiet();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
